// File: rtl/julia_pkg.sv
// Shared types for the Julia result path (collector and pixel writer).
package julia_pkg;

   // Widest geometry a result record carries; narrower instances zero-extend.
   localparam int RES_ADDR_W = 32;
   localparam int RES_DATA_W = 32;
   localparam int RES_SRC_W  = 5;   // up to 32 workers

   // Width of a worker index for n workers.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic [RES_ADDR_W-1:0] addr;
      logic [RES_DATA_W-1:0] data;
      logic [RES_SRC_W-1:0]  src;
   } result_t;

endpackage

// File: rtl/julia_collect_if.sv
// Worker-side request bundle plus the downstream result stream.
interface julia_collect_if
   import julia_pkg::*;
#(
   parameter int NUM_JULIA = 8,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
);
   localparam int SW = src_w(NUM_JULIA);

   logic [NUM_JULIA-1:0]        done;
   logic [NUM_JULIA*ADDR_W-1:0] cataddresses;
   logic [NUM_JULIA*DATA_W-1:0] catpixels;
   logic [NUM_JULIA-1:0]        ack;
   logic                        flush;
   logic                        out_valid;
   logic                        out_ready;
   logic [ADDR_W-1:0]           out_addr;
   logic [DATA_W-1:0]           out_data;
   logic [SW-1:0]               out_src;
   logic [31:0]                 result_count;
   logic                        idle;

   // Drives workers and the downstream consumer.
   modport master (
      output done, cataddresses, catpixels, flush, out_ready,
      input  ack, out_valid, out_addr, out_data, out_src, result_count, idle
   );

   // The collector.
   modport slave (
      input  done, cataddresses, catpixels, flush, out_ready,
      output ack, out_valid, out_addr, out_data, out_src, result_count, idle
   );
endinterface

// File: rtl/julia_collect_rr_arbiter.sv
// One-hot arbiter: round-robin from a rotating pointer, or fixed lowest-index.
module rr_arbiter
   import julia_pkg::*;
#(
   parameter int NUM_JULIA  = 8,
   parameter int FIXED_PRIO = 0,
   localparam int SW        = src_w(NUM_JULIA)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_JULIA-1:0] req,
   input  logic                 en,
   output logic [NUM_JULIA-1:0] grant,
   output logic [SW-1:0]        gnt_idx,
   output logic                 gnt_vld
);
   logic [SW-1:0] ptr;
   int            k;

   // First requester at or after ptr (or from 0 in fixed mode) wins.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      k       = 0;
      for (int i = 0; i < NUM_JULIA; i++) begin
         k = (FIXED_PRIO != 0) ? i : (int'(ptr) + i) % NUM_JULIA;
         if (en && !gnt_vld && req[k]) begin
            gnt_vld  = 1'b1;
            gnt_idx  = SW'(k);
            grant[k] = 1'b1;
         end
      end
   end

   // Pointer moves just past the winner; it stays at 0 in fixed mode.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (FIXED_PRIO == 0 && gnt_vld)
         ptr <= (gnt_idx == SW'(NUM_JULIA - 1)) ? '0 : gnt_idx + 1'b1;
   end
endmodule

// File: rtl/julia_collect.sv
// Arbitrates finished worker results into a small FIFO and streams the head.
// ADDR_W/DATA_W must not exceed the record widths in julia_pkg.
module julia_collect
   import julia_pkg::*;
#(
   parameter int NUM_JULIA  = 8,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int FIXED_PRIO = 0
) (
   input  logic     clk,
   input  logic     rst,
   julia_collect_if.slave bus
);
   localparam int SW = src_w(NUM_JULIA);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   result_t       mem [FIFO_DEPTH];
   result_t       wr_ent, head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   res_cnt;
   logic [SW-1:0] gnt_idx;
   logic          gnt_vld, full, valid, en, push, pop;
   logic          unused_head;

   // A full queue blocks grants regardless of a same-cycle pop, so
   // out_ready never reaches the ack path.
   assign full  = (count == CW'(FIFO_DEPTH));
   assign valid = (count != '0);
   assign en    = !full && !bus.flush && !rst;
   assign push  = gnt_vld;
   assign pop   = valid && bus.out_ready && !bus.flush;

   rr_arbiter #(.NUM_JULIA(NUM_JULIA), .FIXED_PRIO(FIXED_PRIO)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.done),
      .en      (en),
      .grant   (bus.ack),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // Pick the granted worker's address/pixel out of the packed buses.
   always_comb begin
      wr_ent      = '0;
      wr_ent.addr = RES_ADDR_W'(bus.cataddresses[gnt_idx*ADDR_W +: ADDR_W]);
      wr_ent.data = RES_DATA_W'(bus.catpixels[gnt_idx*DATA_W +: DATA_W]);
      wr_ent.src  = RES_SRC_W'(gnt_idx);
   end

   // Storage array; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_ent;
   end

   // Queue pointers and level; flush empties the queue like reset does.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Delivered-result counter; survives flush, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst)      res_cnt <= '0;
      else if (pop) res_cnt <= res_cnt + 32'd1;
   end

   assign head             = mem[rd_ptr];
   assign unused_head      = ^head;
   assign bus.out_valid    = valid;
   assign bus.out_addr     = valid ? head.addr[ADDR_W-1:0] : '0;
   assign bus.out_data     = valid ? head.data[DATA_W-1:0] : '0;
   assign bus.out_src      = valid ? head.src[SW-1:0]      : '0;
   assign bus.result_count = res_cnt;
   assign bus.idle         = !valid && !(|bus.done);
endmodule

// File: doc/julia_collect.md
# julia_collect

Result collector between the Julia worker array and the pixel writer. Each cycle it arbitrates among workers holding a finished pixel and acknowledges exactly one. The accepted address/pixel/source triple is queued in a small FIFO, and the queue head is presented on a valid/ready stream. It replaces the one-shot mask-and-search scheme with fair arbitration, back-pressure, buffering and a result counter.

## Interface
- NUM_JULIA, 8, number of worker channels (2..32)
- ADDR_W, 32, pixel address width
- DATA_W, 32, pixel data width
- FIFO_DEPTH, 4, result queue entries (power of two, ≥2)
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = lowest index wins
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- done  in  NUM_JULIA  worker k holds a finished result
- cataddresses  in  NUM_JULIA*ADDR_W  concatenated worker addresses, k at [k*ADDR_W +: ADDR_W]
- catpixels  in  NUM_JULIA*DATA_W  concatenated worker pixels, same packing
- ack  out  NUM_JULIA  one-hot or zero; worker k's result accepted this cycle
- flush  in  1  discard all queued results
- out_valid  out  1  queue head valid
- out_ready  in  1  downstream accepts head
- out_addr  out  ADDR_W  head address
- out_data  out  DATA_W  head pixel
- out_src  out  $clog2(NUM_JULIA)  head worker index
- result_count  out  32  total results delivered downstream
- idle  out  1  queue empty and no done asserted

## Operation
- The grant is combinational from done, the rotating pointer and the FIFO level.
  - It is asserted only when the FIFO is not full and flush is low.
  - ack = grant.
- Round-robin: search starts at pointer `ptr`. On a grant to worker g, ptr <= (g+1) mod NUM_JULIA. Without a grant, ptr holds.
- FIXED_PRIO=1: the lowest set index wins and ptr is unused (held at 0).
- On grant, {cataddresses[g], catpixels[g], g} is written at the FIFO tail.
- Worker contract: a worker deasserts done, or presents a new result, in the cycle after its ack. A done held through ack counts as a new result.
- Pop occurs when out_valid && out_ready. result_count increments by 1 per pop and wraps at 2^32.
- Full FIFO: no grant, even if a pop happens in the same cycle. This keeps out_ready out of the ack path.
- Simultaneous push and pop when not full: both occur and the level is unchanged.
- Flush has priority over everything:
  - the level goes to 0 and ack is 0 that cycle;
  - any pop is ignored and not counted;
  - ptr and result_count are kept.
- Data on out_addr/out_data/out_src is undefined when out_valid=0. The bench must not check it then.

## Timing
- Reset values: ack=0, out_valid=0, out_addr=0, out_data=0, out_src=0, result_count=0, idle=1 (if done=0), ptr=0, FIFO empty.
- Ack latency: 0 cycles from done (combinational) when space exists.
- Head latency: a result acked in cycle n appears on out_valid in cycle n+1 (first-word fall-through from registers).
- Steady-state throughput: 1 result/cycle with out_ready held high.
- Reset asserted mid-operation discards queue contents at the next edge. Workers not acked lose nothing: their done stays high and is granted after reset.

## Structure
- Package julia_pkg:
  - typedef result_t {addr, data, src};
  - localparam helper for the src width;
  - shared with the pixel writer.
- Sub-module rr_arbiter: NUM_JULIA request vector plus FIXED_PRIO, producing one-hot grant and index, and owning ptr.
- FIFO is inline: a register array of result_t, with wr/rd pointers plus a count of width $clog2(FIFO_DEPTH)+1.

## Test plan
- Reset, then done=8'b0000_0100 for 1 cycle with addr 0x100 and pixel 0xAB -> ack=0000_0100 in the same cycle. Next cycle: out_valid=1, out_addr=0x100, out_data=0xAB, out_src=2.
- done=8'hFF held continuously, each worker dropping done after its ack, out_ready=1 -> acks in order 0,1,…,7, one per cycle. result_count=8 after the final pop.
- out_ready=0, done=8'hFF, FIFO_DEPTH=4 -> exactly 4 acks (workers 0..3), then ack=0 while full. After raising out_ready, acks resume at worker 4, never while count=4.
- FIXED_PRIO=1, done=8'b1000_0001 held on worker 7 -> worker 0 is acked every cycle it requests. Worker 7 is acked only once worker 0 drops done.
- Queue holding 3 entries, flush=1 with out_ready=1 and done=1 -> next cycle out_valid=0, no ack that cycle, result_count unchanged, and ptr preserved (next grant follows the previous rotation).
- rst pulsed while the queue is full -> next cycle out_valid=0, result_count=0, ptr=0. Pending done bits are then granted starting from worker 0.
